// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle add/sub/and/or, iterative shift-add multiply.
// The start/busy/done handshake lets pipeline control stall while a multiply runs.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | accepting start_i; single-cycle ops complete at the accept edge
// S_MUL  | shift-add multiply in flight, one partial product per edge
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;

    logic [0:0]       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] acc_next;

    always_comb begin
        alu_result = '0;
        case (ALUCtrl_i)
            OP_ADD:  alu_result = data1_i + data2_i;
            OP_SUB:  alu_result = data1_i - data2_i;
            OP_AND:  alu_result = data1_i & data2_i;
            OP_OR:   alu_result = data1_i | data2_i;
            default: alu_result = '0;
        endcase
    end

    // Only the low WIDTH bits of the product are kept, so the accumulator
    // needs no extra headroom and signedness does not matter.
    always_comb begin
        addend   = multiplier[0] ? multiplicand : '0;
        acc_next = acc + addend;
    end

    assign busy_o = (state == S_MUL);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            acc          <= '0;
            multiplicand <= '0;
            multiplier   <= '0;
            cnt          <= '0;
            data_o       <= '0;
            zero_o       <= 1'b1;
            done_o       <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        if (ALUCtrl_i == OP_MUL) begin
                            multiplicand <= data1_i;
                            multiplier   <= data2_i;
                            acc          <= '0;
                            cnt          <= '0;
                            state        <= S_MUL;
                        end else begin
                            data_o <= alu_result;
                            zero_o <= (alu_result == '0);
                            done_o <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc          <= acc_next;
                    multiplicand <= multiplicand << 1;
                    multiplier   <= multiplier >> 1;
                    cnt          <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        data_o <= acc_next;
                        zero_o <= (acc_next == '0);
                        done_o <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: single-cycle ops, multiply latency,
// ignored start while busy, reset abort, and the zero-result codes.
module tb_alu_multicycle;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [2:0]  ALUCtrl_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic [31:0] data_o;
    logic        zero_o;
    logic        busy_o;
    logic        done_o;

    int errors = 0;
    int checks = 0;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .ALUCtrl_i (ALUCtrl_i),
        .data1_i   (data1_i),
        .data2_i   (data2_i),
        .data_o    (data_o),
        .zero_o    (zero_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start_i   = s;
        ALUCtrl_i = op;
        data1_i   = a;
        data2_i   = b;
    endtask

    // Issue a multiply, then wait for done while counting busy cycles.
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        int busy_cnt;
        int done_cnt;
        drive(1'b1, 3'd5, a, b);
        tick();
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (done_o) break;
            if (busy_o) busy_cnt++;
            tick();
        end
        check({tag, "_done"}, {31'h0, done_o}, 32'h1);
        check({tag, "_busy_cycles"}, busy_cnt, 32);
        check({tag, "_busy_at_done"}, {31'h0, busy_o}, 32'h0);
        check({tag, "_data"}, data_o, exp);
        check({tag, "_zero"}, {31'h0, zero_o}, {31'h0, exp == 32'h0});
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done_o) done_cnt++;
        end
        check({tag, "_extra_done"}, done_cnt, 0);
        check({tag, "_data_held"}, data_o, exp);
    endtask

    initial begin
        int done_cnt;

        rst_i = 1'b1;
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        tick();
        tick();
        check("rst_data", data_o, 32'h0);
        check("rst_zero", {31'h0, zero_o}, 32'h1);
        check("rst_busy", {31'h0, busy_o}, 32'h0);
        check("rst_done", {31'h0, done_o}, 32'h0);
        rst_i = 1'b0;
        tick();
        check("idle_done", {31'h0, done_o}, 32'h0);

        // Back-to-back single-cycle ops
        drive(1'b1, 3'd1, 32'hFFFF_FFFF, 32'h1);
        tick();
        check("add_data", data_o, 32'h0);
        check("add_zero", {31'h0, zero_o}, 32'h1);
        check("add_done", {31'h0, done_o}, 32'h1);
        drive(1'b1, 3'd2, 32'd5, 32'd7);
        tick();
        check("sub_data", data_o, 32'hFFFF_FFFE);
        check("sub_zero", {31'h0, zero_o}, 32'h0);
        check("sub_done", {31'h0, done_o}, 32'h1);
        drive(1'b1, 3'd3, 32'hF0F0, 32'hFF00);
        tick();
        check("and_data", data_o, 32'hF000);
        check("and_done", {31'h0, done_o}, 32'h1);
        drive(1'b1, 3'd4, 32'hF0F0, 32'h0F0F);
        tick();
        check("or_data", data_o, 32'hFFFF);
        check("or_done", {31'h0, done_o}, 32'h1);
        drive(1'b0, 3'd1, 32'h1234, 32'h1);
        tick();
        check("b2b_done_drop", {31'h0, done_o}, 32'h0);
        check("b2b_hold", data_o, 32'hFFFF);

        // Multiplies
        run_mul("mul_7x6", 32'd7, 32'd6, 32'd42);
        run_mul("mul_ffx2", 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
        run_mul("mul_wrap", 32'h1_0000, 32'h1_0000, 32'h0);

        // start during multiply is ignored
        drive(1'b1, 3'd5, 32'd3, 32'd3);
        tick();
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        done_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 10) drive(1'b1, 3'd1, 32'd1, 32'd1);
            else drive(1'b0, 3'd0, 32'hDEAD, 32'hBEEF);
            tick();
            if (done_o) done_cnt++;
        end
        check("ign_done_count", done_cnt, 1);
        check("ign_data", data_o, 32'd9);

        // Reset aborts a multiply
        drive(1'b1, 3'd5, 32'd100, 32'd100);
        tick();
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        for (int i = 1; i < 15; i++) tick();
        check("abort_busy_before", {31'h0, busy_o}, 32'h1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("abort_busy", {31'h0, busy_o}, 32'h0);
        check("abort_data", data_o, 32'h0);
        check("abort_zero", {31'h0, zero_o}, 32'h1);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done_o) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_data_late", data_o, 32'h0);
        drive(1'b1, 3'd1, 32'd2, 32'd3);
        tick();
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        check("post_add_data", data_o, 32'd5);
        check("post_add_done", {31'h0, done_o}, 32'h1);
        tick();

        // Zero-result codes
        drive(1'b1, 3'd0, 32'h12, 32'h34);
        tick();
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        check("code0_data", data_o, 32'h0);
        check("code0_zero", {31'h0, zero_o}, 32'h1);
        check("code0_done", {31'h0, done_o}, 32'h1);
        tick();
        check("code0_done_drop", {31'h0, done_o}, 32'h0);
        drive(1'b1, 3'd1, 32'h12, 32'h34);
        tick();
        check("pre7_data", data_o, 32'h46);
        drive(1'b1, 3'd7, 32'h12, 32'h34);
        tick();
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        check("code7_data", data_o, 32'h0);
        check("code7_zero", {31'h0, zero_o}, 32'h1);
        check("code7_done", {31'h0, done_o}, 32'h1);
        tick();
        check("code7_done_drop", {31'h0, done_o}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
